// File: rtl/display_buffer.sv
// Display-path output stage: edge-detects register-file display strobes, buffers values in a
// first-word-fall-through FIFO and drains them to the display driver over valid/ready.
module display_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_availiable,
    input  logic [DATA_W-1:0] value,
    input  logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic              all_drained
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDrain    = 2'd1,
        StFinished = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              avail_q;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty, full_w, push_req, push_en, push, pop, drop;

    always_comb begin
        empty    = (count_q == '0);
        full_w   = (count_q == (ADDR_W + 1)'(DEPTH));
        pop      = ~empty & out_ready;
        push_req = display_availiable & ~avail_q;
        push_en  = (state_q == StRun);
        // A pop on the same edge frees the slot, so a push at full is still accepted.
        push     = push_req & push_en & (~full_w | pop);
        drop     = push_req & push_en & full_w & ~pop;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        state_d      = state_q;

        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end

        case (state_q)
            StRun:      if (done) state_d = StDrain;
            StDrain:    if (empty) state_d = StFinished;
            StFinished: state_d = StFinished;
            default:    state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            avail_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            avail_q      <= display_availiable;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is left unreset; its contents are never visible while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= value;
    end

    always_comb begin
        out_valid   = ~empty;
        out_data    = empty ? '0 : mem_q[rd_ptr_q];
        count       = count_q;
        full        = full_w;
        overflow    = overflow_q;
        drop_count  = drop_count_q;
        all_drained = (state_q == StFinished);
    end

endmodule
